// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result bundle for the nibble-serial add/subtract sequencer.
// Handshake: a requester raises start with a, b and op_sub valid; the operation is
// accepted on the first rising edge where the sequencer is idle (busy=0, done=0),
// and done pulses for one cycle when result, c_out and overflow are valid.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic [1:0]       fsm_state;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, c_out, overflow, fsm_state
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, c_out, overflow, fsm_state
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit adder slice reused once per clock,
// least-significant nibble first, with the carry held in a register between cycles.
module nibble_add4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int k = 0; k < 4; k++) begin
            s[k]   = x[k] ^ y[k] ^ c[k];
            c[k+1] = (x[k] & y[k]) | (c[k] & (x[k] ^ y[k]));
        end
    end

    assign co = c[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_add_ctrl_if.slave  bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_eff;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_s;
    logic             slice_co;

    assign slice_a       = a_lat[{idx, 2'b00} +: 4];
    assign slice_b       = b_eff[{idx, 2'b00} +: 4];
    assign bus.fsm_state = state;

    nibble_add4 u_slice (
        .x  (slice_a),
        .y  (slice_b),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // Subtract is a + ~b + 1: the +1 enters through the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.c_out    <= 1'b0;
            bus.overflow <= 1'b0;
            a_lat        <= '0;
            b_eff        <= '0;
            carry        <= 1'b0;
            idx          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_lat    <= bus.a;
                        b_eff    <= bus.op_sub ? ~bus.b : bus.b;
                        carry    <= bus.op_sub;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    bus.result[{idx, 2'b00} +: 4] <= slice_s;
                    carry <= slice_co;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_W'(NIBBLES - 1)) begin
                        bus.c_out    <= slice_co;
                        bus.overflow <= (a_lat[WIDTH-1] == b_eff[WIDTH-1]) &&
                                        (slice_s[3] != a_lat[WIDTH-1]);
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: 16-bit instance for directed/random operations,
// reset and ignored-start cases; 8-bit instance for back-to-back held-start operation.
module tb_nibble_serial_add_ctrl;
    localparam int W  = 16;
    localparam int N  = W / 4;
    localparam int W8 = 8;
    localparam int N8 = W8 / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [W8+1:0] exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(W))  bus16 ();
    nibble_serial_add_ctrl_if #(.WIDTH(W8)) bus8 ();

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    nibble_serial_add_ctrl #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular arithmetic; returns {overflow, c_out, result}.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] av,
                                           input logic [31:0] bv, input logic sub);
        longint mask, ua, ub, r;
        logic   c, v, sa, sb, sr;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        r    = sub ? ((ua - ub) & mask) : ((ua + ub) & mask);
        c    = sub ? (ua >= ub) : ((((ua + ub) >> w) & 1) != 0);
        sa   = ((ua >> (w - 1)) & 1) != 0;
        sb   = ((ub >> (w - 1)) & 1) != 0;
        sr   = ((r  >> (w - 1)) & 1) != 0;
        v    = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {v, c, r[31:0]};
    endfunction

    task automatic run16(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sub, input bit inject);
        logic [33:0]  e;
        logic [W-1:0] prev;
        int           cyc;
        e    = ref_op(W, {16'h0, av}, {16'h0, bv}, sub);
        prev = bus16.result;
        @(negedge clk);
        bus16.start  = 1'b1;
        bus16.a      = av;
        bus16.b      = bv;
        bus16.op_sub = sub;
        @(posedge clk);
        #1;
        bus16.start  = 1'b0;
        bus16.a      = W'($urandom);
        bus16.b      = W'($urandom);
        bus16.op_sub = 1'($urandom);
        check("busy_accept", bus16.busy, 1);
        check("result_hold", bus16.result, prev);
        cyc = 0;
        while (bus16.done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inject) begin
                if (cyc == 1) begin
                    bus16.start  = 1'b1;
                    bus16.a      = W'($urandom);
                    bus16.b      = W'($urandom);
                    bus16.op_sub = 1'($urandom);
                end else begin
                    bus16.start = 1'b0;
                end
            end
            if (bus16.done !== 1'b1 && cyc < N) check("busy_run", bus16.busy, 1);
        end
        bus16.start = 1'b0;
        check("latency", cyc, N);
        check("busy_at_done", bus16.busy, 0);
        check("result", bus16.result, e[W-1:0]);
        check("c_out", bus16.c_out, e[32]);
        check("overflow", bus16.overflow, e[33]);
        @(posedge clk);
        #1;
        check("done_pulse", bus16.done, 0);
        if (inject) begin
            repeat (N + 2) begin
                @(posedge clk);
                #1;
                check("no_extra_done", bus16.done, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            t, k, last;
        logic [W8-1:0] a8, b8;
        logic          s8;
        logic [W8+1:0] e8;
        logic [33:0]   m;

        bus16.start = 1'b0; bus16.op_sub = 1'b0; bus16.a = '0; bus16.b = '0;
        bus8.start  = 1'b0; bus8.op_sub  = 1'b0; bus8.a  = '0; bus8.b  = '0;

        #12;
        check("rst_busy", bus16.busy, 0);
        check("rst_done", bus16.done, 0);
        check("rst_result", bus16.result, 0);
        check("rst_c_out", bus16.c_out, 0);
        check("rst_overflow", bus16.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run16(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run16(16'h0005, 16'h0007, 1'b1, 1'b0);
        run16(16'h8000, 16'h0001, 1'b1, 1'b0);
        run16(W'($urandom), W'($urandom), 1'b0, 1'b1);

        // Reset asserted asynchronously in the third RUN cycle.
        @(negedge clk);
        bus16.start = 1'b1; bus16.a = 16'hABCD; bus16.b = 16'h1357; bus16.op_sub = 1'b0;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus16.busy, 0);
        check("mid_rst_done", bus16.done, 0);
        check("mid_rst_result", bus16.result, 0);
        check("mid_rst_c_out", bus16.c_out, 0);
        check("mid_rst_overflow", bus16.overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 3) begin
            @(posedge clk);
            #1;
            check("post_rst_no_done", bus16.done, 0);
        end
        run16(16'h0001, 16'h0001, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run16(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        // 8-bit instance, start held high for back-to-back operations.
        @(negedge clk);
        a8 = W8'($urandom); b8 = W8'($urandom); s8 = 1'($urandom);
        m  = ref_op(W8, {24'h0, a8}, {24'h0, b8}, s8);
        exp_q.push_back({m[33], m[32], m[W8-1:0]});
        bus8.a = a8; bus8.b = b8; bus8.op_sub = s8; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        t    = 0;
        last = 0;
        for (int op = 0; op < 6; op++) begin
            k = 0;
            while (bus8.done !== 1'b1 && k < 10) begin
                @(posedge clk);
                #1;
                t++;
                k++;
            end
            if (op == 0) check("lat8", t, N8);
            else         check("spacing8", t - last, N8 + 2);
            last = t;
            check("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
            e8 = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("result8", bus8.result, e8[W8-1:0]);
            check("c_out8", bus8.c_out, e8[W8]);
            check("overflow8", bus8.overflow, e8[W8+1]);
            if (op < 5) begin
                a8 = W8'($urandom); b8 = W8'($urandom); s8 = 1'($urandom);
                m  = ref_op(W8, {24'h0, a8}, {24'h0, b8}, s8);
                exp_q.push_back({m[33], m[32], m[W8-1:0]});
                bus8.a = a8; bus8.b = b8; bus8.op_sub = s8;
            end else begin
                bus8.start = 1'b0;
            end
            @(posedge clk);
            #1;
            t++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
